// File: rtl/sram_pixel_unpacker.sv
// sram_pixel_unpacker
//
// Sits behind the SRAM address encoder. Each lookup carries sideband data,
// which is delayed here until it lines up with the SRAM read word. The block
// picks the addressed 4-bit nibble out of that word and composites up to four
// lookups per screen pixel, lowest priority first. It emits one colour index
// per screen pixel.
//
// Object ID encoding (2 bits): 0 = MAP, 1 = BAR, 2 = CAR1, 3 = CAR2.
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_valid               lookup valid, same cycle as the encoder inputs
//   i_object_id           object of this lookup
//   i_object_pixel_index  pixel index; only [1:0] (nibble select) is used here
//   i_first, i_last       first / last lookup of a screen pixel (qualified by i_valid)
//   i_sram_rdata          SRAM read word, READ_LATENCY cycles after the lookup
//   o_valid               one-cycle pulse, composited pixel ready
//   o_color_index         composited colour index (held between pulses)
//   o_object_id           object that supplied the colour (MAP if none opaque)
//   o_opaque              any lookup of the pixel was opaque
//   o_seq_err             one-cycle pulse on a first/last protocol violation
//
// READ_LATENCY must be in 1..4.

module sram_pixel_unpacker #(
  parameter int unsigned READ_LATENCY      = 2,
  parameter logic [3:0]  TRANSPARENT_INDEX = 4'h0,
  parameter logic [3:0]  BG_INDEX          = 4'h0,
  parameter int unsigned INDEX_WIDTH       = 12
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_valid,
  input  logic [1:0]             i_object_id,
  input  logic [INDEX_WIDTH-1:0] i_object_pixel_index,
  input  logic                   i_first,
  input  logic                   i_last,
  input  logic [15:0]            i_sram_rdata,
  output logic                   o_valid,
  output logic [3:0]             o_color_index,
  output logic [1:0]             o_object_id,
  output logic                   o_opaque,
  output logic                   o_seq_err
);

  localparam logic [1:0]  ObjMap = 2'd0;
  localparam int unsigned Tail   = READ_LATENCY - 1;

  // Upper index bits address the SRAM word, which the encoder already used.
  logic unused_index;
  assign unused_index = ^i_object_pixel_index[INDEX_WIDTH-1:2];

  // Sideband delay line
  logic [READ_LATENCY-1:0]      pipe_valid_q;
  logic [READ_LATENCY-1:0]      pipe_first_q;
  logic [READ_LATENCY-1:0]      pipe_last_q;
  logic [READ_LATENCY-1:0][1:0] pipe_id_q;
  logic [READ_LATENCY-1:0][1:0] pipe_sel_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pipe_valid_q <= '0;
      pipe_first_q <= '0;
      pipe_last_q  <= '0;
      pipe_id_q    <= '0;
      pipe_sel_q   <= '0;
    end else begin
      pipe_valid_q[0] <= i_valid;
      // Payload only captured on valid; bubbles keep stale payload harmlessly.
      if (i_valid) begin
        pipe_first_q[0] <= i_first;
        pipe_last_q[0]  <= i_last;
        pipe_id_q[0]    <= i_object_id;
        pipe_sel_q[0]   <= i_object_pixel_index[1:0];
      end
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        pipe_valid_q[i] <= pipe_valid_q[i-1];
        pipe_first_q[i] <= pipe_first_q[i-1];
        pipe_last_q[i]  <= pipe_last_q[i-1];
        pipe_id_q[i]    <= pipe_id_q[i-1];
        pipe_sel_q[i]   <= pipe_sel_q[i-1];
      end
    end
  end

  // Tail of the delay line, aligned with i_sram_rdata
  logic       t_valid, t_first, t_last, t_opaque;
  logic [1:0] t_id, t_sel;
  logic [3:0] t_nibble;

  assign t_valid = pipe_valid_q[Tail];
  assign t_first = pipe_first_q[Tail];
  assign t_last  = pipe_last_q[Tail];
  assign t_id    = pipe_id_q[Tail];
  assign t_sel   = pipe_sel_q[Tail];

  always_comb begin
    t_nibble = i_sram_rdata[3:0];
    unique case (t_sel)
      2'd0: t_nibble = i_sram_rdata[3:0];
      2'd1: t_nibble = i_sram_rdata[7:4];
      2'd2: t_nibble = i_sram_rdata[11:8];
      2'd3: t_nibble = i_sram_rdata[15:12];
      default: t_nibble = i_sram_rdata[3:0];
    endcase
  end

  // The map layer is the backdrop and is never transparent.
  assign t_opaque = (t_id == ObjMap) || (t_nibble != TRANSPARENT_INDEX);

  // Accumulator and registered outputs
  logic [3:0] acc_color_q, acc_color_d;
  logic [1:0] acc_id_q, acc_id_d;
  logic       acc_opaque_q, acc_opaque_d;
  logic       open_q, open_d;
  logic       out_valid_q, out_valid_d;
  logic [3:0] out_color_q, out_color_d;
  logic [1:0] out_id_q, out_id_d;
  logic       out_opaque_q, out_opaque_d;
  logic       seq_err_q, seq_err_d;
  logic       accept;

  always_comb begin
    acc_color_d  = acc_color_q;
    acc_id_d     = acc_id_q;
    acc_opaque_d = acc_opaque_q;
    open_d       = open_q;
    out_valid_d  = 1'b0;
    out_color_d  = out_color_q;
    out_id_d     = out_id_q;
    out_opaque_d = out_opaque_q;
    seq_err_d    = 1'b0;
    accept       = 1'b0;

    if (t_valid) begin
      if (t_first) begin
        // A still-open pixel is abandoned; the new one starts regardless.
        seq_err_d = open_q;
        accept    = 1'b1;
        open_d    = 1'b1;
        if (t_opaque) begin
          acc_color_d  = t_nibble;
          acc_id_d     = t_id;
          acc_opaque_d = 1'b1;
        end else begin
          acc_color_d  = BG_INDEX;
          acc_id_d     = ObjMap;
          acc_opaque_d = 1'b0;
        end
      end else if (open_q) begin
        accept = 1'b1;
        if (t_opaque) begin
          acc_color_d  = t_nibble;
          acc_id_d     = t_id;
          acc_opaque_d = 1'b1;
        end
      end else begin
        // Orphan continuation: dropped, including any last flag it carries.
        seq_err_d = 1'b1;
      end

      if (accept && t_last) begin
        out_valid_d  = 1'b1;
        out_color_d  = acc_color_d;
        out_id_d     = acc_id_d;
        out_opaque_d = acc_opaque_d;
        open_d       = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_color_q  <= 4'h0;
      acc_id_q     <= ObjMap;
      acc_opaque_q <= 1'b0;
      open_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_color_q  <= 4'h0;
      out_id_q     <= ObjMap;
      out_opaque_q <= 1'b0;
      seq_err_q    <= 1'b0;
    end else begin
      acc_color_q  <= acc_color_d;
      acc_id_q     <= acc_id_d;
      acc_opaque_q <= acc_opaque_d;
      open_q       <= open_d;
      out_valid_q  <= out_valid_d;
      out_color_q  <= out_color_d;
      out_id_q     <= out_id_d;
      out_opaque_q <= out_opaque_d;
      seq_err_q    <= seq_err_d;
    end
  end

  assign o_valid       = out_valid_q;
  assign o_color_index = out_color_q;
  assign o_object_id   = out_id_q;
  assign o_opaque      = out_opaque_q;
  assign o_seq_err     = seq_err_q;

endmodule

// File: tb/tb_sram_pixel_unpacker.sv
// Testbench for sram_pixel_unpacker.
// The stimulus side models the SRAM: it schedules each lookup's word for its
// tail cycle and keeps a list-level model of the current pixel. Expected
// pixels and seq errors are queued with the cycle they are due. A monitor
// pops them and compares whenever the DUT presents them. Two extra instances
// (READ_LATENCY 1 and 4) are checked for latency on a single lookup.

module tb_sram_pixel_unpacker;

  localparam int         L      = 2;
  localparam int         IDXW   = 12;
  localparam logic [1:0] MAP    = 2'd0;
  localparam logic [1:0] BAR    = 2'd1;
  localparam logic [1:0] CAR1   = 2'd2;
  localparam logic [1:0] CAR2   = 2'd3;
  localparam logic [3:0] TRANSP = 4'h0;
  localparam logic [3:0] BG     = 4'hB;

  typedef struct {
    int         cyc;
    logic [3:0] color;
    logic [1:0] id;
    logic       opq;
  } exp_t;

  typedef struct {
    logic [1:0] id;
    logic [3:0] nib;
  } pix_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            vld, first, last;
  logic [1:0]      oid;
  logic [IDXW-1:0] idx;
  logic [15:0]     rdata;
  logic [15:0]     rdata_fix;

  logic       o_valid, o_opaque, o_seq_err;
  logic [3:0] o_color;
  logic [1:0] o_id;
  logic       v1, q1, e1, v4, q4, e4;
  logic [3:0] c1, c4;
  logic [1:0] i1, i4;

  always #5 clk = ~clk;

  sram_pixel_unpacker #(
    .READ_LATENCY(L), .TRANSPARENT_INDEX(TRANSP), .BG_INDEX(BG), .INDEX_WIDTH(IDXW)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(vld), .i_object_id(oid),
    .i_object_pixel_index(idx), .i_first(first), .i_last(last), .i_sram_rdata(rdata),
    .o_valid(o_valid), .o_color_index(o_color), .o_object_id(o_id), .o_opaque(o_opaque),
    .o_seq_err(o_seq_err)
  );

  sram_pixel_unpacker #(.READ_LATENCY(1), .INDEX_WIDTH(IDXW)) dut_l1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(vld), .i_object_id(oid),
    .i_object_pixel_index(idx), .i_first(first), .i_last(last), .i_sram_rdata(rdata_fix),
    .o_valid(v1), .o_color_index(c1), .o_object_id(i1), .o_opaque(q1), .o_seq_err(e1)
  );

  sram_pixel_unpacker #(.READ_LATENCY(4), .INDEX_WIDTH(IDXW)) dut_l4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(vld), .i_object_id(oid),
    .i_object_pixel_index(idx), .i_first(first), .i_last(last), .i_sram_rdata(rdata_fix),
    .o_valid(v4), .o_color_index(c4), .o_object_id(i4), .o_opaque(q4), .o_seq_err(e4)
  );

  int          cyc    = 0;
  int          errors = 0;
  int          checks = 0;
  logic [15:0] sched[16];
  exp_t        exp_q[$];
  int          err_q[$];
  pix_t        pix_q[$];
  bit          open_m = 1'b0;
  logic [3:0]  hold_color = 4'h0;
  logic [1:0]  hold_id    = MAP;
  logic        hold_opq   = 1'b0;

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp_v);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    rdata = sched[cyc % 16];
    sched[cyc % 16] = 16'($urandom);
  endtask

  // Issue one lookup; the model works on the whole list of a pixel's lookups.
  task automatic issue(input logic [1:0] id, input logic [IDXW-1:0] ix, input logic f,
                       input logic la, input logic [15:0] word);
    pix_t p;
    exp_t e;
    bit   take;
    sched[(cyc + L) % 16] = word;
    p.id  = id;
    p.nib = 4'((word >> (4 * int'(ix[1:0]))) & 16'hF);
    take  = 1'b1;
    if (f) begin
      if (open_m) err_q.push_back(cyc + L + 1);
      pix_q.delete();
      open_m = 1'b1;
    end else if (!open_m) begin
      err_q.push_back(cyc + L + 1);
      take = 1'b0;
    end
    if (take) begin
      pix_q.push_back(p);
      if (la) begin
        e.cyc = cyc + L + 1; e.color = BG; e.id = MAP; e.opq = 1'b0;
        foreach (pix_q[i]) begin
          if (pix_q[i].id == MAP || pix_q[i].nib != TRANSP) begin
            e.color = pix_q[i].nib; e.id = pix_q[i].id; e.opq = 1'b1;
          end
        end
        exp_q.push_back(e);
        open_m = 1'b0;
      end
    end
    vld = 1'b1; oid = id; idx = ix; first = f; last = la;
    tick();
    vld = 1'b0; oid = 2'($urandom); idx = IDXW'($urandom);
    first = 1'($urandom); last = 1'($urandom);
  endtask

  function automatic logic [15:0] mkword(input logic [1:0] s, input logic [3:0] n);
    logic [15:0] w;
    w = 16'($urandom);
    w[int'(s) * 4 +: 4] = n;
    return w;
  endfunction

  task automatic rand_issue(input logic [1:0] id, input logic f, input logic la);
    logic [IDXW-1:0] ix;
    logic [15:0]     w;
    ix = IDXW'($urandom);
    w  = 16'($urandom);
    if ($urandom_range(0, 9) < 4) w[int'(ix[1:0]) * 4 +: 4] = TRANSP;
    issue(id, ix, f, la, w);
  endtask

  task automatic reset_model();
    exp_q.delete(); err_q.delete(); pix_q.delete();
    open_m = 1'b0; hold_color = 4'h0; hold_id = MAP; hold_opq = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, int'(o_valid), 0);
    check({tag, "_color"}, int'(o_color), 0);
    check({tag, "_id"}, int'(o_id), int'(MAP));
    check({tag, "_opaque"}, int'(o_opaque), 0);
    check({tag, "_seq_err"}, int'(o_seq_err), 0);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (rst_n) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        flag("o_valid_missing");
        void'(exp_q.pop_front());
      end
      while (err_q.size() > 0 && err_q[0] < cyc) begin
        flag("seq_err_missing");
        void'(err_q.pop_front());
      end
      if (o_valid) begin
        if (exp_q.size() == 0) begin
          flag("o_valid_unexpected");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("o_valid_cycle", cyc, e.cyc);
          check("o_color_index", int'(o_color), int'(e.color));
          check("o_object_id", int'(o_id), int'(e.id));
          check("o_opaque", int'(o_opaque), int'(e.opq));
          hold_color = e.color; hold_id = e.id; hold_opq = e.opq;
        end
      end else begin
        check("hold_color", int'(o_color), int'(hold_color));
        check("hold_id", int'(o_id), int'(hold_id));
        check("hold_opaque", int'(o_opaque), int'(hold_opq));
      end
      if (o_seq_err) begin
        if (err_q.size() == 0) flag("seq_err_unexpected");
        else check("seq_err_cycle", cyc, err_q.pop_front());
      end
    end
  end

  initial begin
    int seen1, seen4;
    rst_n = 1'b0; vld = 1'b0; first = 1'b0; last = 1'b0; oid = MAP; idx = '0;
    rdata = 16'h0; rdata_fix = 16'hA5C3;
    for (int i = 0; i < 16; i++) sched[i] = 16'($urandom);
    #2;
    check_reset_outputs("reset");
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Single MAP lookup, index 6 -> sel 2 -> nibble 5; latency on all three instances
    seen1 = 0; seen4 = 0;
    issue(MAP, 12'h006, 1'b1, 1'b1, 16'hA5C3);
    for (int k = 1; k <= 7; k++) begin
      if (v1 && seen1 == 0) begin
        seen1 = k;
        check("l1_color", int'(c1), 5); check("l1_id", int'(i1), int'(MAP));
        check("l1_opaque", int'(q1), 1);
      end
      if (v4 && seen4 == 0) begin
        seen4 = k;
        check("l4_color", int'(c4), 5); check("l4_id", int'(i4), int'(MAP));
        check("l4_opaque", int'(q4), 1);
      end
      tick();
    end
    check("l1_latency", seen1, 2);
    check("l4_latency", seen4, 5);

    // MAP, BAR, CAR1, CAR2 back to back; cars transparent -> BAR 7
    issue(MAP, 12'h101, 1'b1, 1'b0, mkword(2'd1, 4'h3));
    issue(BAR, 12'h202, 1'b0, 1'b0, mkword(2'd2, 4'h7));
    issue(CAR1, 12'h303, 1'b0, 1'b0, mkword(2'd3, 4'h0));
    issue(CAR2, 12'h000, 1'b0, 1'b1, mkword(2'd0, 4'h0));
    repeat (2) tick();

    // Same with a bubble after BAR, CAR2 opaque 9
    issue(MAP, 12'h101, 1'b1, 1'b0, mkword(2'd1, 4'h3));
    issue(BAR, 12'h202, 1'b0, 1'b0, mkword(2'd2, 4'h7));
    tick();
    issue(CAR1, 12'h303, 1'b0, 1'b0, mkword(2'd3, 4'h0));
    issue(CAR2, 12'h000, 1'b0, 1'b1, mkword(2'd0, 4'h9));
    repeat (2) tick();

    // CAR1-only transparent pixel, then nibble select on 16'h4321
    issue(CAR1, 12'h002, 1'b1, 1'b1, mkword(2'd2, 4'h0));
    for (int s = 0; s < 4; s++) issue(MAP, IDXW'(s), 1'b1, 1'b1, 16'h4321);
    repeat (4) tick();

    // Protocol errors: restart mid-pixel, then an orphan continuation
    issue(MAP, 12'h001, 1'b1, 1'b0, mkword(2'd1, 4'h2));
    issue(BAR, 12'h002, 1'b0, 1'b0, mkword(2'd2, 4'h6));
    issue(MAP, 12'h003, 1'b1, 1'b0, mkword(2'd3, 4'h1));
    issue(CAR2, 12'h000, 1'b0, 1'b1, mkword(2'd0, 4'hE));
    issue(CAR1, 12'h001, 1'b0, 1'b1, mkword(2'd1, 4'h8));
    issue(MAP, 12'h002, 1'b1, 1'b0, mkword(2'd2, 4'h4));
    issue(BAR, 12'h003, 1'b0, 1'b1, mkword(2'd3, 4'hD));
    repeat (L + 3) tick();

    // Reset with three lookups in flight
    issue(MAP, 12'h001, 1'b1, 1'b0, mkword(2'd1, 4'h2));
    issue(BAR, 12'h002, 1'b0, 1'b0, mkword(2'd2, 4'h6));
    issue(CAR1, 12'h003, 1'b0, 1'b1, mkword(2'd3, 4'h9));
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    reset_model();
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (L + 3) tick();
    issue(MAP, 12'h006, 1'b1, 1'b1, 16'hA5C3);
    issue(BAR, 12'h003, 1'b1, 1'b1, mkword(2'd3, 4'hC));
    repeat (L + 3) tick();

    // Randomized pixels with occasional protocol errors and bubbles
    for (int p = 0; p < 300; p++) begin
      int mask, n, k;
      if ($urandom_range(0, 19) == 0) rand_issue(2'($urandom), 1'b0, 1'($urandom));
      if ($urandom_range(0, 19) == 0) rand_issue(MAP, 1'b1, 1'b0);
      mask = $urandom_range(1, 15);
      n = $countones(mask);
      k = 0;
      for (int id = 0; id < 4; id++) begin
        if (mask[id]) begin
          if (k > 0 && $urandom_range(0, 3) == 0) tick();
          rand_issue(2'(id), k == 0, k == n - 1);
          k++;
        end
      end
      if ($urandom_range(0, 3) == 0) tick();
    end

    repeat (L + 6) tick();
    check("pending_outputs", exp_q.size(), 0);
    check("pending_seq_errs", err_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
